// File: rtl/burst_sampler.sv
// burst_sampler
//   Waits for a transition into TRIG_LEVEL on the synchronised RX line and
//   captures SAMPLE_COUNT samples spaced CLK_PER_SAMPLE clocks apart. It then
//   presents the burst with a valid/ack handshake. After each ack it enforces
//   HOLDOFF idle clocks before it re-arms.
//
// Ports
//   clk          sample clock
//   rst_n        asynchronous active-low reset
//   signal       raw RX line, asynchronous to clk
//   enable       arms the trigger; low aborts a capture in progress
//   sample_ack   consumer accepts the presented burst
//   sample       captured burst, first sample at the MSB
//   sample_valid burst ready, held until acked
//   busy         high while capturing
//   overrun      sticky: a trigger edge arrived while a burst awaited ack
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | armed when enable is high; waits for a trigger edge
// CAPTURE | shifting in samples at prescaler terminal count
// VALID   | burst frozen and presented; waits for sample_ack
// HOLD    | post-ack hold-off; trigger edges ignored
module burst_sampler #(
  parameter int   SAMPLE_COUNT   = 80,
  parameter int   CLK_PER_SAMPLE = 1,
  parameter int   HOLDOFF        = 0,
  parameter logic TRIG_LEVEL     = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    signal,
  input  logic                    enable,
  input  logic                    sample_ack,
  output logic [SAMPLE_COUNT-1:0] sample,
  output logic                    sample_valid,
  output logic                    busy,
  output logic                    overrun
);

  localparam int CW = $clog2(SAMPLE_COUNT);
  localparam int PW = (CLK_PER_SAMPLE > 1) ? $clog2(CLK_PER_SAMPLE) : 1;
  localparam int HW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

  localparam logic [CW-1:0] CNT_LOAD  = CW'(SAMPLE_COUNT - 1);
  localparam logic [PW-1:0] PSC_LOAD  = PW'(CLK_PER_SAMPLE - 1);
  localparam logic [HW-1:0] HOLD_LOAD = (HOLDOFF > 0) ? HW'(HOLDOFF - 1) : '0;

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    VALID,
    HOLD
  } state_t;

  state_t state, state_d;

  logic s1, s2, prev;
  logic trigger;

  logic [CW-1:0]           cnt, cnt_d;
  logic [PW-1:0]           psc, psc_d;
  logic [HW-1:0]           hold_cnt, hold_d;
  logic [SAMPLE_COUNT-1:0] sample_d;
  logic                    overrun_d;

  // Synchroniser and edge history reset to the active level so that a line
  // already active at reset release is not seen as a fresh edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1   <= TRIG_LEVEL;
      s2   <= TRIG_LEVEL;
      prev <= TRIG_LEVEL;
    end else begin
      s1   <= signal;
      s2   <= s1;
      prev <= s2;
    end
  end

  assign trigger = (s2 == TRIG_LEVEL) && (prev != TRIG_LEVEL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      psc      <= '0;
      hold_cnt <= '0;
      sample   <= '0;
      overrun  <= 1'b0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      psc      <= psc_d;
      hold_cnt <= hold_d;
      sample   <= sample_d;
      overrun  <= overrun_d;
    end
  end

  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    psc_d     = psc;
    hold_d    = hold_cnt;
    sample_d  = sample;
    overrun_d = overrun;

    unique case (state)
      IDLE: begin
        // The trigger cycle itself supplies sample 0.
        if (enable && trigger) begin
          sample_d  = {sample[SAMPLE_COUNT-2:0], s2};
          cnt_d     = CNT_LOAD;
          psc_d     = PSC_LOAD;
          overrun_d = 1'b0;
          state_d   = CAPTURE;
        end
      end

      CAPTURE: begin
        // An abort keeps the partial burst but never raises valid.
        if (!enable) begin
          state_d = IDLE;
        end else if (psc == '0) begin
          sample_d = {sample[SAMPLE_COUNT-2:0], s2};
          psc_d    = PSC_LOAD;
          cnt_d    = cnt - 1'b1;
          if (cnt == CW'(1)) begin
            state_d = VALID;
          end
        end else begin
          psc_d = psc - 1'b1;
        end
      end

      VALID: begin
        // The edge is recorded even when ack lands in the same cycle.
        if (trigger) begin
          overrun_d = 1'b1;
        end
        if (sample_ack) begin
          if (HOLDOFF > 0) begin
            hold_d  = HOLD_LOAD;
            state_d = HOLD;
          end else begin
            state_d = IDLE;
          end
        end
      end

      HOLD: begin
        if (hold_cnt == '0) begin
          state_d = IDLE;
        end else begin
          hold_d = hold_cnt - 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign busy         = (state == CAPTURE);
  assign sample_valid = (state == VALID);

endmodule

// File: tb/tb_burst_sampler.sv
// Bench for burst_sampler. Two instances are exercised side by side:
//   dut_a: 80 samples, 1 clock per sample, no hold-off
//   dut_b: 8 samples, 4 clocks per sample, 10 clocks hold-off
// A timestamp-based model predicts every output of both instances each
// cycle. Directed sequences add literal expectations that pin the model.
module tb_burst_sampler;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sig [2];
  logic en  [2];
  logic ack [2];

  logic [79:0] sample_a;
  logic [7:0]  sample_b;
  logic        sample_valid_a, busy_a, overrun_a;
  logic        sample_valid_b, busy_b, overrun_b;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  burst_sampler #(
    .SAMPLE_COUNT(80), .CLK_PER_SAMPLE(1), .HOLDOFF(0), .TRIG_LEVEL(1'b1)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .signal(sig[0]), .enable(en[0]),
    .sample_ack(ack[0]), .sample(sample_a), .sample_valid(sample_valid_a),
    .busy(busy_a), .overrun(overrun_a)
  );

  burst_sampler #(
    .SAMPLE_COUNT(8), .CLK_PER_SAMPLE(4), .HOLDOFF(10), .TRIG_LEVEL(1'b1)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .signal(sig[1]), .enable(en[1]),
    .sample_ack(ack[1]), .sample(sample_b), .sample_valid(sample_valid_b),
    .busy(busy_b), .overrun(overrun_b)
  );

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int cfg_n(input int d);
    return (d == 0) ? 80 : 8;
  endfunction
  function automatic int cfg_p(input int d);
    return (d == 0) ? 1 : 4;
  endfunction
  function automatic int cfg_h(input int d);
    return (d == 0) ? 0 : 10;
  endfunction
  function automatic logic [79:0] cfg_mask(input int d);
    return (d == 0) ? {80{1'b1}} : 80'hFF;
  endfunction

  // Model: m_cap holds the trigger cycle of a running capture (-1 if none),
  // m_arm the first cycle a new trigger may be accepted.
  logic        m_s1 [2], m_s2 [2], m_prev [2], m_val [2], m_ovr [2];
  int          m_cap [2], m_arm [2];
  logic [79:0] m_smp [2];
  logic        m_trig;
  int          cyc = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int d = 0; d < 2; d++) begin
        m_s1[d] = 1'b1; m_s2[d] = 1'b1; m_prev[d] = 1'b1;
        m_val[d] = 1'b0; m_ovr[d] = 1'b0;
        m_cap[d] = -1; m_arm[d] = 0; m_smp[d] = '0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        m_trig = m_s2[d] && !m_prev[d];
        if (m_val[d]) begin
          if (m_trig) m_ovr[d] = 1'b1;
          if (ack[d]) begin
            m_val[d] = 1'b0;
            m_arm[d] = cyc + 1 + cfg_h(d);
          end
        end else if (m_cap[d] >= 0) begin
          if (!en[d]) begin
            m_cap[d] = -1;
          end else if ((cyc - m_cap[d]) % cfg_p(d) == 0) begin
            m_smp[d] = ((m_smp[d] << 1) | 80'(m_s2[d])) & cfg_mask(d);
            if (cyc == m_cap[d] + (cfg_n(d) - 1) * cfg_p(d)) begin
              m_cap[d] = -1;
              m_val[d] = 1'b1;
            end
          end
        end else if (cyc >= m_arm[d] && en[d] && m_trig) begin
          m_cap[d] = cyc;
          m_smp[d] = ((m_smp[d] << 1) | 80'(m_s2[d])) & cfg_mask(d);
          m_ovr[d] = 1'b0;
        end
        m_prev[d] = m_s2[d];
        m_s2[d]   = m_s1[d];
        m_s1[d]   = sig[d];
      end
      cyc++;
    end
  end

  always @(negedge clk) begin
    check("cmp_busy_a",   80'(busy_a),         80'(m_cap[0] >= 0));
    check("cmp_valid_a",  80'(sample_valid_a), 80'(m_val[0]));
    check("cmp_ovr_a",    80'(overrun_a),      80'(m_ovr[0]));
    check("cmp_sample_a", sample_a,            m_smp[0]);
    check("cmp_busy_b",   80'(busy_b),         80'(m_cap[1] >= 0));
    check("cmp_valid_b",  80'(sample_valid_b), 80'(m_val[1]));
    check("cmp_ovr_b",    80'(overrun_b),      80'(m_ovr[1]));
    check("cmp_sample_b", {72'b0, sample_b},   m_smp[1]);
  end

  logic [79:0] pat_a5 = 80'hA5A5_A5A5_A5A5_A5A5_A5A5;
  int          bits_b [8] = '{1, 0, 1, 1, 0, 0, 1, 0};
  int          busy_cnt, vfirst, vcnt;

  initial begin
    for (int d = 0; d < 2; d++) begin
      sig[d] = 1'b0; en[d] = 1'b0; ack[d] = 1'b0;
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_busy_a",   80'(busy_a), 80'd0);
    check("rst_valid_a",  80'(sample_valid_a), 80'd0);
    check("rst_ovr_a",    80'(overrun_a), 80'd0);
    check("rst_sample_a", sample_a, 80'd0);

    // Basic burst: trigger bit 1 then 79 bits of the A5 pattern.
    en[0] = 1'b1;
    repeat (3) @(negedge clk);
    busy_cnt = 0; vfirst = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (busy_a) busy_cnt++;
      if (sample_valid_a && vfirst < 0) vfirst = i;
      sig[0] = (i == 0) ? 1'b1 : ((i < 80) ? pat_a5[80-i] : 1'b0);
    end
    check("basic_sample", sample_a, 80'hD2D2_D2D2_D2D2_D2D2_D2D2);
    check("basic_busy_len", 80'(busy_cnt), 80'd79);
    // two synchroniser clocks plus T+80
    check("basic_valid_rise", 80'(vfirst), 80'd82);

    // Overrun: un-acked burst, fresh edge.
    sig[0] = 1'b1;
    repeat (5) @(negedge clk);
    check("ovr_set", 80'(overrun_a), 80'd1);
    check("ovr_sample_frozen", sample_a, 80'hD2D2_D2D2_D2D2_D2D2_D2D2);
    check("ovr_valid_held", 80'(sample_valid_a), 80'd1);
    ack[0] = 1'b1;
    @(negedge clk);
    ack[0] = 1'b0;
    check("ack_valid_fall", 80'(sample_valid_a), 80'd0);
    check("ovr_sticky", 80'(overrun_a), 80'd1);
    sig[0] = 1'b0;
    repeat (4) @(negedge clk);
    sig[0] = 1'b1;
    repeat (4) @(negedge clk);
    check("retrig_busy", 80'(busy_a), 80'd1);
    check("retrig_ovr_clear", 80'(overrun_a), 80'd0);

    // Abort mid-capture.
    en[0] = 1'b0;
    @(negedge clk);
    check("abort_busy", 80'(busy_a), 80'd0);
    vcnt = 0;
    repeat (100) begin
      @(negedge clk);
      if (sample_valid_a) vcnt++;
    end
    check("abort_no_valid", 80'(vcnt), 80'd0);
    en[0] = 1'b1;

    // Reset during capture, line held high through release.
    sig[0] = 1'b0;
    repeat (4) @(negedge clk);
    sig[0] = 1'b1;
    repeat (10) @(negedge clk);
    check("pre_rst_busy", 80'(busy_a), 80'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_busy",   80'(busy_a), 80'd0);
    check("async_rst_valid",  80'(sample_valid_a), 80'd0);
    check("async_rst_ovr",    80'(overrun_a), 80'd0);
    check("async_rst_sample", sample_a, 80'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    busy_cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy_a) busy_cnt++;
    end
    check("rst_release_no_trig", 80'(busy_cnt), 80'd0);

    // Prescaled burst on dut_b.
    en[1] = 1'b1; sig[1] = 1'b0;
    repeat (4) @(negedge clk);
    busy_cnt = 0; vfirst = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy_b) busy_cnt++;
      if (sample_valid_b && vfirst < 0) vfirst = i;
      sig[1] = (i < 32) ? 1'(bits_b[i/4]) : 1'b0;
    end
    check("presc_sample", {72'b0, sample_b}, 80'hB2);
    check("presc_busy_len", 80'(busy_cnt), 80'd28);
    // two synchroniser clocks plus T+29
    check("presc_valid_rise", 80'(vfirst), 80'd31);

    // Hold-off: edge at ack+5 ignored, edge at ack+11 accepted.
    ack[1] = 1'b1;
    @(negedge clk);
    ack[1] = 1'b0;
    check("hold_valid_fall", 80'(sample_valid_b), 80'd0);
    @(negedge clk);
    @(negedge clk);
    sig[1] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    sig[1] = 1'b0;
    repeat (3) @(negedge clk);
    check("hold_ignored_busy", 80'(busy_b), 80'd0);
    check("hold_ignored_ovr", 80'(overrun_b), 80'd0);
    @(negedge clk);
    sig[1] = 1'b1;
    repeat (3) @(negedge clk);
    check("hold_rearm_busy", 80'(busy_b), 80'd1);
    repeat (40) @(negedge clk);
    check("hold_burst_valid", 80'(sample_valid_b), 80'd1);
    check("hold_burst_sample", {72'b0, sample_b}, 80'hFF);
    ack[1] = 1'b1;
    @(negedge clk);
    ack[1] = 1'b0;
    repeat (20) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/burst_sampler.md
# burst_sampler

Parametrised successor to the RX single-burst sampler: waits for an active edge on the synchronised RX PCB output, captures a burst of `SAMPLE_COUNT` samples spaced `CLK_PER_SAMPLE` clocks apart, then presents the burst word with a valid/ack handshake. A programmable hold-off follows each burst. It sits between the RX front-end and the RX decoder, in the sample-clock domain.

## Interface

Parameters:
- `SAMPLE_COUNT`, default 80: samples per burst; must be ≥ 2.
- `CLK_PER_SAMPLE`, default 1: clocks between successive samples; must be ≥ 1.
- `HOLDOFF`, default 0: idle clocks enforced after ack before re-arming; must be ≥ 0.
- `TRIG_LEVEL`, default 1'b1: active level. The trigger is a transition into this level.

Ports:
- `clk`, input, 1: sample clock.
- `rst_n`, input, 1: reset. Asynchronous, active-low.
- `signal`, input, 1: raw RX PCB output, asynchronous to `clk`.
- `enable`, input, 1: arms the trigger. Low aborts a capture in progress.
- `sample_ack`, input, 1: consumer accepts the burst.
- `sample`, output, `SAMPLE_COUNT`: captured burst. The first sample is at the MSB.
- `sample_valid`, output, 1: burst ready. Held until acked.
- `busy`, output, 1: high in CAPTURE.
- `overrun`, output, 1: sticky. A trigger edge arrived while a burst was awaiting ack.

## Operation

- **Synchroniser.** `signal` passes through 2 flops (`s1`→`s2`). `prev` holds the last `s2`. `s1`, `s2` and `prev` all reset to `TRIG_LEVEL`, so a line already active at reset release does not trigger.
- **Trigger.** `s2 == TRIG_LEVEL && prev != TRIG_LEVEL`.
- **States:** IDLE, CAPTURE, VALID, HOLD.
- **IDLE:**
  - Leaves only when `enable && trigger`.
  - On that cycle T, shift `s2` into `sample` (shift left, new bit at LSB), load the sample counter with `SAMPLE_COUNT-1` and the prescaler with `CLK_PER_SAMPLE-1`, clear `overrun`, and go to CAPTURE.
- **CAPTURE:**
  - The prescaler decrements each clock.
  - At prescaler zero: shift `s2` in, reload the prescaler, decrement the sample counter.
  - When the shift consuming the last sample happens (counter reaches 0), go to VALID.
  - Trigger edges are ignored.
  - `enable` low: go to IDLE next cycle. `sample` keeps its partial contents, and no valid is raised.
- **VALID:**
  - `sample_valid = 1`; `sample` is frozen.
  - `sample_ack` high: go to HOLD if `HOLDOFF > 0`, else IDLE.
  - A trigger edge here sets `overrun` and is otherwise dropped.
  - `enable` low does not cancel VALID.
- **HOLD:**
  - Count `HOLDOFF` clocks, then go to IDLE.
  - Triggers are ignored and do not set `overrun`.
- **Widths.** The sample counter is `$clog2(SAMPLE_COUNT)` bits. The prescaler is `max(1, $clog2(CLK_PER_SAMPLE))` bits. With `CLK_PER_SAMPLE == 1` the prescaler is always zero, so one sample is taken per clock.
- **Reset values:**
  - `sample` = 0; `sample_valid` = 0; `busy` = 0; `overrun` = 0.
  - State = IDLE; counters = 0.
  - Reset mid-capture or mid-VALID discards everything immediately (asynchronous).

## Timing

- `signal` to `s2`: 2 clocks. The trigger cycle T is the first cycle in which `s2` shows the active level.
- **Sample instants.** Sample k (k = 0..`SAMPLE_COUNT`-1) is `s2` at cycle T + k·`CLK_PER_SAMPLE`. Sample 0 ends up at `sample[SAMPLE_COUNT-1]` and the last sample at `sample[0]`.
- **`busy`.** High from T+1 through the cycle of the last shift, i.e. T+(N-1)·P (inclusive). It is a registered state decode.
- **`sample_valid`.** Rises at T+(N-1)·P+1 (registered). It falls on the clock after `sample_ack` is sampled high.
- **Minimum re-arm.** The earliest new trigger accepted is at ack+1+`HOLDOFF`. A trigger on the same cycle IDLE is entered is accepted.
- **Ack outside VALID.** `sample_ack` outside VALID is ignored.
- **Simultaneous events.**
  - Ack and trigger in the same VALID cycle: ack wins and `overrun` is set.
  - `enable` falling on trigger cycle T: no capture starts.

## Test plan

- **Basic burst** (N=80, P=1, TRIG_LEVEL=1): idle low, then drive 1 followed by the 79-bit pattern 0xA5A5…
  - `busy` is high for 79 clocks.
  - `sample` = {1, pattern}.
  - `sample_valid` rises 80 clocks after T and holds until ack, then falls 1 clock later.
- **Prescaled burst** (N=8, P=4): drive `signal` changing every 4 clocks, starting with bit 1 at the trigger, as 1,0,1,1,0,0,1,0 (aligned to the sample instants).
  - `sample` = 8'hB2.
  - `sample_valid` rises at T+29.
- **Overrun:** leave VALID un-acked and toggle `signal` 0→1.
  - `overrun` = 1 and `sample` is unchanged.
  - After ack, the next trigger clears `overrun`.
- **Hold-off** (HOLDOFF=10): drive a trigger edge 5 clocks after ack.
  - It is ignored and `overrun` stays 0.
  - An edge at ack+11 starts a capture.
- **Abort:** pull `enable` low mid-capture.
  - State returns to IDLE next cycle, `busy` = 0, and `sample_valid` never rises.
- **Reset during capture:** assert `rst_n` low mid-capture.
  - All outputs go to 0 asynchronously.
  - Holding `signal` high through reset release produces no spurious trigger.
